// File: rtl/mam_mem_arbiter.sv
// ============================================================================
// Module      : mam_mem_arbiter
// Description : Round-robin arbiter sharing one burst memory port between two
//               MAM requesters; one transaction owns the port until complete.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mam_mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_valid,
  input  logic                    m0_req_rw,
  input  logic                    m0_req_burst,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic [13:0]             m0_req_beats,
  output logic                    m0_req_ready,
  input  logic                    m0_write_valid,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [DATA_WIDTH/8-1:0] m0_write_strb,
  output logic                    m0_write_ready,
  output logic                    m0_read_valid,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  input  logic                    m0_read_ready,
  input  logic                    m1_req_valid,
  input  logic                    m1_req_rw,
  input  logic                    m1_req_burst,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [13:0]             m1_req_beats,
  output logic                    m1_req_ready,
  input  logic                    m1_write_valid,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [DATA_WIDTH/8-1:0] m1_write_strb,
  output logic                    m1_write_ready,
  output logic                    m1_read_valid,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  input  logic                    m1_read_ready,
  output logic                    s_req_valid,
  output logic                    s_req_rw,
  output logic                    s_req_burst,
  output logic [ADDR_WIDTH-1:0]   s_req_addr,
  output logic [13:0]             s_req_beats,
  input  logic                    s_req_ready,
  output logic                    s_write_valid,
  output logic [DATA_WIDTH-1:0]   s_write_data,
  output logic [DATA_WIDTH/8-1:0] s_write_strb,
  input  logic                    s_write_ready,
  input  logic                    s_read_valid,
  input  logic [DATA_WIDTH-1:0]   s_read_data,
  output logic                    s_read_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t      r_state, w_next_state;
  logic        r_grant, w_next_grant;
  logic        r_prio,  w_next_prio;
  logic [13:0] r_count, w_next_count;

  // Fields of whichever requester currently owns the port
  logic                    w_req_valid, w_req_rw, w_req_burst;
  logic [ADDR_WIDTH-1:0]   w_req_addr;
  logic [13:0]             w_req_beats;
  logic                    w_write_valid, w_read_ready;
  logic [DATA_WIDTH-1:0]   w_write_data;
  logic [DATA_WIDTH/8-1:0] w_write_strb;

  always_comb begin
    w_req_valid   = r_grant ? m1_req_valid   : m0_req_valid;
    w_req_rw      = r_grant ? m1_req_rw      : m0_req_rw;
    w_req_burst   = r_grant ? m1_req_burst   : m0_req_burst;
    w_req_addr    = r_grant ? m1_req_addr    : m0_req_addr;
    w_req_beats   = r_grant ? m1_req_beats   : m0_req_beats;
    w_write_valid = r_grant ? m1_write_valid : m0_write_valid;
    w_write_data  = r_grant ? m1_write_data  : m0_write_data;
    w_write_strb  = r_grant ? m1_write_strb  : m0_write_strb;
    w_read_ready  = r_grant ? m1_read_ready  : m0_read_ready;
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_grant   = r_grant;
    w_next_prio    = r_prio;
    w_next_count   = r_count;
    m0_req_ready   = 1'b0;
    m1_req_ready   = 1'b0;
    m0_write_ready = 1'b0;
    m1_write_ready = 1'b0;
    m0_read_valid  = 1'b0;
    m1_read_valid  = 1'b0;
    m0_read_data   = '0;
    m1_read_data   = '0;
    s_req_valid    = 1'b0;
    s_req_rw       = 1'b0;
    s_req_burst    = 1'b0;
    s_req_addr     = '0;
    s_req_beats    = '0;
    s_write_valid  = 1'b0;
    s_write_data   = '0;
    s_write_strb   = '0;
    s_read_ready   = 1'b0;

    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req_valid || m1_req_valid) begin
            w_next_grant = (m0_req_valid && m1_req_valid) ? r_prio : m1_req_valid;
            w_next_state = ST_REQ;
          end
        end

        ST_REQ: begin
          s_req_valid = w_req_valid;
          s_req_rw    = w_req_rw;
          s_req_burst = w_req_burst;
          s_req_addr  = w_req_addr;
          s_req_beats = w_req_beats;
          if (r_grant) m1_req_ready = s_req_ready;
          else         m0_req_ready = s_req_ready;
          // A withdrawn request gives up its slot without rotating priority
          if (!w_req_valid) begin
            w_next_state = ST_IDLE;
          end else if (s_req_ready) begin
            w_next_count = (w_req_burst && (w_req_beats != 14'd0)) ? w_req_beats : 14'd1;
            w_next_state = w_req_rw ? ST_WRITE : ST_READ;
          end
        end

        ST_WRITE: begin
          s_write_valid = w_write_valid;
          s_write_data  = w_write_data;
          s_write_strb  = w_write_strb;
          if (r_grant) m1_write_ready = s_write_ready;
          else         m0_write_ready = s_write_ready;
          if (w_write_valid && s_write_ready) begin
            if (r_count <= 14'd1) begin
              w_next_state = ST_IDLE;
              w_next_prio  = ~r_grant;
            end else begin
              w_next_count = r_count - 14'd1;
            end
          end
        end

        ST_READ: begin
          s_read_ready = w_read_ready;
          if (r_grant) begin
            m1_read_valid = s_read_valid;
            m1_read_data  = s_read_data;
          end else begin
            m0_read_valid = s_read_valid;
            m0_read_data  = s_read_data;
          end
          if (s_read_valid && w_read_ready) begin
            if (r_count <= 14'd1) begin
              w_next_state = ST_IDLE;
              w_next_prio  = ~r_grant;
            end else begin
              w_next_count = r_count - 14'd1;
            end
          end
        end

        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
      r_count <= 14'd0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_prio  <= w_next_prio;
      r_count <= w_next_count;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mam_mem_arbiter.sv
// ============================================================================
// Module      : tb_mam_mem_arbiter
// Description : Directed self-checking bench for mam_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mam_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_rw, m0_req_burst, m0_req_ready;
  logic [31:0] m0_req_addr;
  logic [13:0] m0_req_beats;
  logic        m0_write_valid, m0_write_ready, m0_read_valid, m0_read_ready;
  logic [15:0] m0_write_data, m0_read_data;
  logic [1:0]  m0_write_strb;
  logic        m1_req_valid, m1_req_rw, m1_req_burst, m1_req_ready;
  logic [31:0] m1_req_addr;
  logic [13:0] m1_req_beats;
  logic        m1_write_valid, m1_write_ready, m1_read_valid, m1_read_ready;
  logic [15:0] m1_write_data, m1_read_data;
  logic [1:0]  m1_write_strb;
  logic        s_req_valid, s_req_rw, s_req_burst, s_req_ready;
  logic [31:0] s_req_addr;
  logic [13:0] s_req_beats;
  logic        s_write_valid, s_write_ready, s_read_valid, s_read_ready;
  logic [15:0] s_write_data, s_read_data;
  logic [1:0]  s_write_strb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mam_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_rw(m0_req_rw), .m0_req_burst(m0_req_burst),
    .m0_req_addr(m0_req_addr), .m0_req_beats(m0_req_beats), .m0_req_ready(m0_req_ready),
    .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data), .m0_write_strb(m0_write_strb),
    .m0_write_ready(m0_write_ready), .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data),
    .m0_read_ready(m0_read_ready),
    .m1_req_valid(m1_req_valid), .m1_req_rw(m1_req_rw), .m1_req_burst(m1_req_burst),
    .m1_req_addr(m1_req_addr), .m1_req_beats(m1_req_beats), .m1_req_ready(m1_req_ready),
    .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data), .m1_write_strb(m1_write_strb),
    .m1_write_ready(m1_write_ready), .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data),
    .m1_read_ready(m1_read_ready),
    .s_req_valid(s_req_valid), .s_req_rw(s_req_rw), .s_req_burst(s_req_burst),
    .s_req_addr(s_req_addr), .s_req_beats(s_req_beats), .s_req_ready(s_req_ready),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_write_ready(s_write_ready), .s_read_valid(s_read_valid), .s_read_data(s_read_data),
    .s_read_ready(s_read_ready)
  );

  task automatic clear_inputs();
    m0_req_valid = 0; m0_req_rw = 0; m0_req_burst = 0; m0_req_addr = '0; m0_req_beats = '0;
    m0_write_valid = 0; m0_write_data = '0; m0_write_strb = 2'b11; m0_read_ready = 0;
    m1_req_valid = 0; m1_req_rw = 0; m1_req_burst = 0; m1_req_addr = '0; m1_req_beats = '0;
    m1_write_valid = 0; m1_write_data = '0; m1_write_strb = 2'b11; m1_read_ready = 0;
    s_req_ready = 0; s_write_ready = 0; s_read_valid = 0; s_read_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m0_req_valid = 1; s_req_ready = 1; s_write_ready = 1; s_read_valid = 1; s_read_data = 16'h1234;
    @(negedge clk); #1;
    tests++;
    if ({s_req_valid, s_write_valid, s_read_ready, m0_req_ready, m1_req_ready} !== 5'b0)
      begin fails++; $display("FAIL reset_handshakes: got %b, want 00000",
        {s_req_valid, s_write_valid, s_read_ready, m0_req_ready, m1_req_ready}); end
    tests++;
    if ({m0_read_valid, m1_read_valid, m0_read_data, m1_read_data} !== 34'b0)
      begin fails++; $display("FAIL reset_read_side: got rv=%b%b rd=%h/%h, want all 0",
        m0_read_valid, m1_read_valid, m0_read_data, m1_read_data); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  // Tie after reset: m0 single write first, one IDLE cycle, then m1
  task automatic test_tie_writes();
    @(negedge clk);
    m0_req_valid = 1; m0_req_rw = 1; m0_req_addr = 32'h100; m0_req_beats = 14'd5;
    m1_req_valid = 1; m1_req_rw = 1; m1_req_addr = 32'h200; m1_req_beats = 14'd5;
    m0_write_valid = 1; m0_write_data = 16'h000f; m1_write_valid = 1; m1_write_data = 16'h000c;
    s_req_ready = 1; s_write_ready = 1;
    #1;
    tests++;
    if (s_req_valid !== 1'b0 || m0_req_ready !== 1'b0)
      begin fails++; $display("FAIL tie_idle_no_ready: got s_req_valid=%b m0_req_ready=%b, want 0 0",
        s_req_valid, m0_req_ready); end
    @(negedge clk); #1;
    tests++;
    if (s_req_valid !== 1 || s_req_addr !== 32'h100 || m0_req_ready !== 1 || m1_req_ready !== 0)
      begin fails++; $display("FAIL tie_grant_m0: got v=%b addr=%h r0=%b r1=%b, want 1 00000100 1 0",
        s_req_valid, s_req_addr, m0_req_ready, m1_req_ready); end
    @(negedge clk); m0_req_valid = 0; #1;
    tests++;
    if (s_write_valid !== 1 || s_write_data !== 16'h000f || m1_write_ready !== 0)
      begin fails++; $display("FAIL tie_write_m0: got v=%b data=%h m1_wr=%b, want 1 000f 0",
        s_write_valid, s_write_data, m1_write_ready); end
    @(negedge clk); m0_write_valid = 0; #1;
    tests++;
    if (s_write_valid !== 0 || s_req_valid !== 0)
      begin fails++; $display("FAIL tie_idle_bubble: got wv=%b rv=%b, want 0 0", s_write_valid, s_req_valid); end
    @(negedge clk); #1;
    tests++;
    if (s_req_valid !== 1 || s_req_addr !== 32'h200 || m1_req_ready !== 1 || m0_req_ready !== 0)
      begin fails++; $display("FAIL tie_grant_m1: got v=%b addr=%h r0=%b r1=%b, want 1 00000200 0 1",
        s_req_valid, s_req_addr, m0_req_ready, m1_req_ready); end
    @(negedge clk); m1_req_valid = 0; #1;
    tests++;
    if (s_write_valid !== 1 || s_write_data !== 16'h000c)
      begin fails++; $display("FAIL tie_write_m1: got v=%b data=%h, want 1 000c", s_write_valid, s_write_data); end
    @(negedge clk); m1_write_valid = 0; #1;
    tests++;
    if (s_write_valid !== 0)
      begin fails++; $display("FAIL tie_single_beat_end: got s_write_valid=%b, want 0", s_write_valid); end
  endtask

  // m0 7-beat write with a 25-cycle stall; m1 burst read waits behind it
  task automatic test_burst_write();
    int idx = 0;
    int hold = 0;
    @(negedge clk);
    clear_inputs();
    m0_req_valid = 1; m0_req_rw = 1; m0_req_burst = 1; m0_req_beats = 14'd7; m0_req_addr = 32'h300;
    m1_req_valid = 1; m1_req_rw = 0; m1_req_burst = 1; m1_req_beats = 14'd4; m1_req_addr = 32'h400;
    m0_write_valid = 1; s_req_ready = 1;
    @(negedge clk); #1;
    tests++;
    if (m0_req_ready !== 1 || s_req_beats !== 14'd7 || s_req_burst !== 1)
      begin fails++; $display("FAIL bw_request: got r0=%b beats=%0d burst=%b, want 1 7 1",
        m0_req_ready, s_req_beats, s_req_burst); end
    for (int cyc = 0; cyc < 60 && idx < 7; cyc++) begin
      @(negedge clk);
      m0_req_valid = 0;
      m0_write_data = 16'(idx);
      s_write_ready = (cyc >= 25);
      #1;
      if (m1_req_ready !== 0 || s_req_valid !== 0) hold++;
      if (s_write_valid && s_write_ready) begin
        tests++;
        if (s_write_data !== 16'(idx))
          begin fails++; $display("FAIL bw_beat_data: beat %0d got %h, want %h", idx, s_write_data, 16'(idx)); end
        idx++;
      end
    end
    tests++;
    if (idx !== 7) begin fails++; $display("FAIL bw_beat_count: got %0d, want 7", idx); end
    tests++;
    if (hold !== 0) begin fails++; $display("FAIL bw_m1_held_off: got %0d leaked cycles, want 0", hold); end
    @(negedge clk); m0_write_valid = 0; #1;
    tests++;
    if (s_write_valid !== 0 || s_req_valid !== 0)
      begin fails++; $display("FAIL bw_idle_bubble: got wv=%b rv=%b, want 0 0", s_write_valid, s_req_valid); end
    @(negedge clk); #1;
    tests++;
    if (s_req_valid !== 1 || m1_req_ready !== 1 || s_req_addr !== 32'h400 || s_req_rw !== 0)
      begin fails++; $display("FAIL bw_then_m1: got v=%b r1=%b addr=%h rw=%b, want 1 1 00000400 0",
        s_req_valid, m1_req_ready, s_req_addr, s_req_rw); end
  endtask

  // Continues m1's accepted 4-beat read with a toggling read_ready
  task automatic test_burst_read();
    int k = 0;
    int bad = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(negedge clk);
      m1_req_valid = 0;
      s_read_valid = 1;
      s_read_data = 16'h00a0 + 16'(k);
      m1_read_ready = (cyc % 2 == 1);
      #1;
      if (s_read_ready !== m1_read_ready || m0_read_valid !== 0 || m0_read_data !== 0 || m1_read_valid !== 1) bad++;
      if (m1_read_valid && m1_read_ready) begin
        tests++;
        if (m1_read_data !== 16'h00a0 + 16'(k))
          begin fails++; $display("FAIL br_beat_data: beat %0d got %h, want %h", k, m1_read_data, 16'h00a0 + 16'(k)); end
        k++;
      end
    end
    tests++;
    if (k !== 4) begin fails++; $display("FAIL br_beat_count: got %0d, want 4", k); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL br_mirroring: got %0d bad cycles, want 0", bad); end
    @(negedge clk); #1;
    tests++;
    if (m1_read_valid !== 0 || s_read_ready !== 0)
      begin fails++; $display("FAIL br_end: got rv=%b rr=%b, want 0 0", m1_read_valid, s_read_ready); end
  endtask

  task automatic test_zero_beats();
    @(negedge clk);
    clear_inputs();
    m0_req_valid = 1; m0_req_burst = 1; m0_req_beats = 14'd0; m0_req_addr = 32'h500; s_req_ready = 1;
    @(negedge clk); #1;
    tests++;
    if (s_req_valid !== 1 || s_req_beats !== 14'd0 || m0_req_ready !== 1)
      begin fails++; $display("FAIL zb_request: got v=%b beats=%0d r0=%b, want 1 0 1", s_req_valid, s_req_beats, m0_req_ready); end
    @(negedge clk);
    m0_req_valid = 0; s_read_valid = 1; s_read_data = 16'h5a5a; m0_read_ready = 1;
    #1;
    tests++;
    if (m0_read_valid !== 1 || m0_read_data !== 16'h5a5a || m1_read_valid !== 0)
      begin fails++; $display("FAIL zb_beat: got v=%b data=%h m1v=%b, want 1 5a5a 0", m0_read_valid, m0_read_data, m1_read_valid); end
    @(negedge clk); #1;
    tests++;
    if (m0_read_valid !== 0 || s_read_ready !== 0)
      begin fails++; $display("FAIL zb_one_beat_end: got v=%b rr=%b, want 0 0", m0_read_valid, s_read_ready); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    clear_inputs();
    m0_req_valid = 1; m0_req_rw = 1; m0_req_burst = 1; m0_req_beats = 14'd6; m0_req_addr = 32'h600;
    m0_write_valid = 1; m0_write_data = 16'hbeef; s_req_ready = 1; s_write_ready = 1;
    @(negedge clk);
    @(negedge clk); m0_req_valid = 0; #1;
    tests++;
    if (s_write_valid !== 1) begin fails++; $display("FAIL rmw_in_write: got s_write_valid=%b, want 1", s_write_valid); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1; #1;
    tests++;
    if ({s_write_valid, m0_write_ready, s_write_data, s_write_strb, s_req_valid, s_read_ready,
         m0_read_valid, m1_read_valid} !== 24'b0)
      begin fails++; $display("FAIL rmw_outputs_zero: got wv=%b wr=%b data=%h strb=%b, want 0 0 0000 00",
        s_write_valid, m0_write_ready, s_write_data, s_write_strb); end
    @(negedge clk);
    rst = 0;
    clear_inputs();
    m1_req_valid = 1; m1_req_addr = 32'h700; s_req_ready = 1;
    @(negedge clk); #1;
    tests++;
    if (s_req_valid !== 1 || m1_req_ready !== 1 || s_req_addr !== 32'h700)
      begin fails++; $display("FAIL rmw_m1_request: got v=%b r1=%b addr=%h, want 1 1 00000700", s_req_valid, m1_req_ready, s_req_addr); end
    @(negedge clk);
    m1_req_valid = 0; s_read_valid = 1; s_read_data = 16'h7777; m1_read_ready = 1;
    #1;
    tests++;
    if (m1_read_valid !== 1 || m1_read_data !== 16'h7777)
      begin fails++; $display("FAIL rmw_m1_read: got v=%b data=%h, want 1 7777", m1_read_valid, m1_read_data); end
    @(negedge clk); #1;
    tests++;
    if (m1_read_valid !== 0) begin fails++; $display("FAIL rmw_m1_end: got v=%b, want 0", m1_read_valid); end
  endtask

  // m0 always requesting, m1 once: grant order must be m0, m1, m0
  task automatic test_fairness();
    logic [2:0] grants = 3'b111;
    int ng = 0;
    bit drop = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    clear_inputs();
    m0_req_valid = 1; m0_req_rw = 1; m1_req_valid = 1; m1_req_rw = 1;
    m0_write_valid = 1; m1_write_valid = 1; s_req_ready = 1; s_write_ready = 1;
    for (int cyc = 0; cyc < 30 && ng < 3; cyc++) begin
      @(negedge clk);
      if (drop) m1_req_valid = 0;
      #1;
      if (s_req_valid && s_req_ready) begin
        grants[ng] = m1_req_ready;
        if (m1_req_ready) drop = 1;
        ng++;
      end
    end
    tests++;
    if (ng !== 3) begin fails++; $display("FAIL rr_grant_count: got %0d, want 3", ng); end
    tests++;
    if (grants !== 3'b010)
      begin fails++; $display("FAIL rr_order: got m%0d,m%0d,m%0d, want m0,m1,m0", grants[0], grants[1], grants[2]); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_tie_writes();
    test_burst_write();
    test_burst_read();
    test_zero_beats();
    test_reset_mid_write();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mam_mem_arbiter.md
MAM_MEM_ARBITER -- requirements
Module: mam_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, memory data width; ADDR_WIDTH, 32, memory address width.
REQ-002 Ports SHALL be, with i = 0,1 for the two requesters (MAM-side ports m0_, m1_) and s_ for the shared memory port:
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  reset, asynchronous, active-high
  m<i>_req_valid / m<i>_req_rw / m<i>_req_burst  in  1 each  request valid, 1=write 0=read, burst flag
  m<i>_req_addr  in  ADDR_WIDTH  start address
  m<i>_req_beats  in  14  burst length in words
  m<i>_req_ready  out  1  request accepted
  m<i>_write_valid  in  1  write beat valid
  m<i>_write_data  in  DATA_WIDTH  write beat data
  m<i>_write_strb  in  DATA_WIDTH/8  byte strobes
  m<i>_write_ready  out  1  write beat accepted
  m<i>_read_valid  out  1  read beat valid
  m<i>_read_data  out  DATA_WIDTH  read beat data
  m<i>_read_ready  in  1  requester accepts read beat
  s_req_valid / s_req_rw / s_req_burst  out  1 each  forwarded request fields
  s_req_addr  out  ADDR_WIDTH;  s_req_beats  out  14
  s_req_ready  in  1
  s_write_valid  out  1;  s_write_data  out  DATA_WIDTH;  s_write_strb  out  DATA_WIDTH/8
  s_write_ready  in  1
  s_read_valid  in  1;  s_read_data  in  DATA_WIDTH
  s_read_ready  out  1

Function
REQ-003 States SHALL be IDLE, REQ, WRITE, READ; registers: state, grant (1 bit), prio (1 bit), beat counter (14 bit).
REQ-004 IDLE: if any m<i>_req_valid, grant <= requester selected by REQ-005, state <= REQ; else stay; no m<i>_req_ready asserted in IDLE.
REQ-005 Arbitration SHALL be round-robin: both valid -> grant = prio; one valid -> that one.
REQ-006 REQ: s_req_* SHALL equal m<grant>_req_*; m<grant>_req_ready = s_req_ready; other requester's ready = 0.
REQ-007 On REQ handshake (s_req_valid & s_req_ready): counter <= req_burst ? req_beats : 1, with req_beats = 0 treated as 1; state <= WRITE if rw=1 else READ.
REQ-008 WRITE: s_write_* = m<grant>_write_*; m<grant>_write_ready = s_write_ready; counter decrements per write handshake.
REQ-009 READ: m<grant>_read_valid = s_read_valid, m<grant>_read_data = s_read_data, s_read_ready = m<grant>_read_ready; counter decrements per read handshake.
REQ-010 Handshake with counter = 1 SHALL end the transaction: state <= IDLE, prio <= ~grant; next arbitration one cycle later (IDLE bubble mandatory).
REQ-011 Non-granted requester SHALL see req_ready, write_ready, read_valid = 0 at all times; read_data to it = 0.
REQ-012 Outside WRITE, s_write_valid = 0; outside READ, s_read_ready = 0; outside REQ, s_req_valid = 0.
REQ-013 Grant SHALL NOT change between REQ entry and return to IDLE, whatever the other requester does; a dropped m<grant>_req_valid in REQ returns state to IDLE without prio change.
REQ-014 Single-beat access (burst=0) SHALL complete after exactly one data handshake regardless of req_beats.

Reset
REQ-015 rst asserted SHALL immediately force state=IDLE, grant=0, prio=0, counter=0; all outputs 0, including mid-burst; first grant after reset favours m0 on a tie.

Verification
REQ-016 Reset mid-WRITE burst (3 of 6 beats done) -> all outputs 0 same cycle; after release, fresh m1 read proceeds normally.
REQ-017 m0 and m1 request simultaneously after reset, both single writes (0x000f, 0x000c) -> s_write_data 0x000f (m0) then 0x000c (m1), one IDLE cycle between.
REQ-018 m0 burst write, beats=7, data 0x0000..0x0006, s_write_ready low for 25 cycles then high -> exactly 7 s_write handshakes in order, m1 request held off until return to IDLE.
REQ-019 m1 burst read beats=4, m1_read_ready toggling -> m1 receives 4 beats in order; m0_read_valid stays 0; s_read_ready mirrors m1_read_ready.
REQ-020 Burst with req_beats=0 -> treated as one beat; return to IDLE after one handshake, no hang.
REQ-021 m0 requests continuously while m1 requests once -> grants alternate m0, m1, m0 (no starvation).
